// File: rtl/qsram_refresh_array.sv
// Quasi-static RAM array (DEPTH x WIDTH) with a 1-cycle request/response port and a refresh controller.
// Optional per-row retention ageing is enabled by defining QSRAM_RETENTION_CHECK_EN.
module qsram_refresh_array #(
    parameter int WIDTH            = 8,
    parameter int DEPTH            = 20,
    parameter int ADDR_W           = 5,
    parameter int REFRESH_INTERVAL = 64,
    parameter int MAX_POSTPONE     = 4,
    parameter int RETENTION        = 2048
) (
    input  logic                              Clock,
    input  logic                              ResetN,
    input  logic                              ReqValid,
    output logic                              ReqReady,
    input  logic                              ReqWrite,
    input  logic [ADDR_W-1:0]                 ReqAddr,
    input  logic [WIDTH-1:0]                  ReqData,
    output logic                              RespValid,
    output logic [WIDTH-1:0]                  RespData,
    output logic                              RespErr,
    input  logic                              RefreshHold,
    output logic                              RefreshBusy,
    output logic [ADDR_W-1:0]                 RefreshRow,
    output logic [$clog2(MAX_POSTPONE+1)-1:0] RefreshPending
);

    localparam int PendW  = $clog2(MAX_POSTPONE + 1);
    localparam int TimerW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RowW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [TimerW-1:0] TimerLast = TimerW'(REFRESH_INTERVAL - 1);
    localparam logic [PendW-1:0]  PendMax   = PendW'(MAX_POSTPONE);
    localparam logic [ADDR_W-1:0] RowLast   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthExt  = (ADDR_W + 1)'(DEPTH);

    if ((2 ** ADDR_W) < DEPTH) begin : gBadAddrW
        $error("qsram_refresh_array: ADDR_W too narrow for DEPTH");
    end
    if (REFRESH_INTERVAL < 2) begin : gBadInterval
        $error("qsram_refresh_array: REFRESH_INTERVAL must be at least 2");
    end
    if (MAX_POSTPONE < 1) begin : gBadPostpone
        $error("qsram_refresh_array: MAX_POSTPONE must be at least 1");
    end
    if (RETENTION < 1) begin : gBadRetention
        $error("qsram_refresh_array: RETENTION must be at least 1");
    end

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [TimerW-1:0] timer_q, timer_d;
    logic [PendW-1:0]  pending_q, pending_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              respValid_q;
    logic [WIDTH-1:0]  respData_q;
    logic              respErr_q;

    logic              tick;
    logic              grant;
    logic              accept;
    logic              addrInRange;
    logic [RowW-1:0]   reqRow;
    logic [RowW-1:0]   refRow;
    logic              readExpired;
    logic              refreshExpired;

    assign tick        = (timer_q == TimerLast);
    assign grant       = (pending_q != '0) && (!RefreshHold || (pending_q == PendMax));
    assign accept      = ReqValid && ReqReady;
    assign addrInRange = ({1'b0, ReqAddr} < DepthExt);
    assign reqRow      = ReqAddr[RowW-1:0];
    assign refRow      = row_q[RowW-1:0];

    assign ReqReady       = !grant && ResetN;
    assign RefreshBusy    = grant;
    assign RefreshRow     = row_q;
    assign RefreshPending = pending_q;
    assign RespValid      = respValid_q;
    assign RespData       = respData_q;
    assign RespErr        = respErr_q;

`ifdef QSRAM_RETENTION_CHECK_EN
    localparam int AgeW = $clog2(RETENTION + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(RETENTION);

    logic [AgeW-1:0] age_q [DEPTH];

    assign readExpired    = addrInRange && !ReqWrite && (age_q[reqRow] == AgeMax);
    assign refreshExpired = (age_q[refRow] == AgeMax);

    // A row's age restarts whenever its charge is restored by a write or a refresh.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((grant && (refRow == RowW'(i))) ||
                    (accept && ReqWrite && addrInRange && (reqRow == RowW'(i)))) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AgeMax) begin
                    age_q[i] <= age_q[i] + AgeW'(1);
                end
            end
        end
    end
`else
    assign readExpired    = 1'b0;
    assign refreshExpired = 1'b0;
`endif

    always_comb begin
        timer_d   = tick ? '0 : timer_q + TimerW'(1);
        pending_d = pending_q;
        row_d     = row_q;
        if (grant) begin
            row_d = (row_q == RowLast) ? '0 : row_q + ADDR_W'(1);
        end
        // A tick coinciding with a refresh cancels out; a tick at saturation is dropped.
        if (tick && !grant && (pending_q != PendMax)) begin
            pending_d = pending_q + PendW'(1);
        end else if (!tick && grant) begin
            pending_d = pending_q - PendW'(1);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            timer_q   <= '0;
            pending_q <= '0;
            row_q     <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
        end
    end

    // Refresh and host access are mutually exclusive because grant masks ReqReady.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (grant) begin
            if (refreshExpired) begin
                mem_q[refRow] <= '0;
            end else begin
                mem_q[refRow] <= mem_q[refRow];
            end
        end else if (accept) begin
            if (ReqWrite && addrInRange) begin
                mem_q[reqRow] <= ReqData;
            end else if (readExpired) begin
                mem_q[reqRow] <= '0;
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            respValid_q <= 1'b0;
            respData_q  <= '0;
            respErr_q   <= 1'b0;
        end else begin
            respValid_q <= accept;
            if (accept) begin
                respErr_q <= !addrInRange || readExpired;
                if (ReqWrite) begin
                    respData_q <= ReqData;
                end else if (addrInRange && !readExpired) begin
                    respData_q <= mem_q[reqRow];
                end else begin
                    respData_q <= '0;
                end
            end
        end
    end

endmodule
